// File: rtl/mux_2x1_rr_out_stage_if.sv
// Handshake and bus bundle between the 2:1 merge output stage, its upstream
// mux and the next NoC hop.
// The slave modport is the output stage itself. The master modport is the
// environment around it: the sources, the mux and the downstream hop.
interface mux_2x1_rr_out_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic [1:0]            i_src_valid;
  logic [1:0]            o_src_ready;
  logic                  o_mux_en;
  logic                  o_mux_cmd;
  logic                  i_mux_valid;
  logic [DATA_WIDTH-1:0] i_mux_data;
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_data_bus;
  logic                  i_ready;

  modport slave (
    input  i_src_valid, i_mux_valid, i_mux_data, i_ready,
    output o_src_ready, o_mux_en, o_mux_cmd, o_valid, o_data_bus
  );

  modport master (
    output i_src_valid, i_mux_valid, i_mux_data, i_ready,
    input  o_src_ready, o_mux_en, o_mux_cmd, o_valid, o_data_bus
  );
endinterface

// File: rtl/mux_2x1_rr_out_stage.sv
// 2:1 merge output stage.
// It arbitrates between the two sources, steers the upstream mux and
// captures the selected word into a small FIFO. The FIFO head is presented
// downstream with valid/ready flow control.
// Build option MUX_2X1_FIXED_PRIO_EN: when defined, the low source always
// wins a tie. Otherwise (the default) ties are resolved round-robin.
module mux_2x1_rr_out_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  mux_2x1_rr_out_stage_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  full;
  logic                  empty;
  logic [1:0]            req;
  logic                  grant;
  logic                  push;
  logic                  pop;

  // The MSB of each pointer is a wrap bit. Equal indices with differing
  // wrap bits mean the FIFO is full.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign req   = full ? 2'b00 : bus.i_src_valid;
  assign push  = bus.o_mux_en & bus.i_mux_valid;
  assign pop   = ~empty & bus.i_ready;

`ifdef MUX_2X1_FIXED_PRIO_EN
  // Fixed priority: only a lone high request selects the high branch.
  always_comb begin
    grant = 1'b0;
    if (req == 2'b10) grant = 1'b1;
  end
`else
  logic last_grant;

  // Round-robin: a lone requester wins; a tie or idle selects the branch not
  // granted last.
  always_comb begin
    grant = ~last_grant;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      default: grant = ~last_grant;
    endcase
  end

  // Remember which source got the most recent accepted word.
  always_ff @(posedge clk) begin
    if (!rst_n)    last_grant <= 1'b1;
    else if (push) last_grant <= grant;
  end
`endif

  assign bus.o_mux_en    = |req;
  assign bus.o_mux_cmd   = grant;
  assign bus.o_src_ready = push ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign bus.o_valid     = ~empty;
  assign bus.o_data_bus  = mem[rd_ptr[AW-1:0]];

  // FIFO pointers; the push is already gated by full through o_mux_en.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // FIFO storage; cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr[AW-1:0]] <= bus.i_mux_data;
    end
  end
endmodule

// File: tb/tb_mux_2x1_rr_out_stage.sv
module tb_mux_2x1_rr_out_stage;
  localparam int DW    = 32;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic kill;
  logic [DW-1:0] data_hi, data_lo;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 0;

  mux_2x1_rr_out_stage_if #(.DATA_WIDTH(DW)) bus ();

  mux_2x1_rr_out_stage #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Upstream mux model: it selects by cmd and is valid only when enabled and
  // the selected source is valid. kill forces an invalid output.
  assign bus.i_mux_valid = bus.o_mux_en & bus.i_src_valid[bus.o_mux_cmd] & ~kill;
  assign bus.i_mux_data  = bus.o_mux_cmd ? data_hi : data_lo;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: the FIFO contents as a queue plus the last winner.
  logic [DW-1:0] q[$];
  int            lg = 1;
  bit            m_push, m_pop, m_cmd;
  logic [DW-1:0] m_din;

  always @(negedge clk) begin
    logic [1:0] r;
    bit en;
    r  = (q.size() == DEPTH) ? 2'b00 : bus.i_src_valid;
    en = (r != 2'b00);
`ifdef MUX_2X1_FIXED_PRIO_EN
    m_cmd = (r == 2'b10);
`else
    m_cmd = (r == 2'b10) ? 1'b1 : (r == 2'b01) ? 1'b0 : bit'(lg == 0);
`endif
    m_push = en && bus.i_src_valid[m_cmd] && !kill;
    m_pop  = (q.size() > 0) && bus.i_ready;
    m_din  = m_cmd ? data_hi : data_lo;
    if (check_en) begin
      chk("mux_en", 64'(bus.o_mux_en), 64'(en));
      chk("mux_cmd", 64'(bus.o_mux_cmd), 64'(m_cmd));
      chk("src_ready", 64'(bus.o_src_ready), m_push ? (m_cmd ? 64'd2 : 64'd1) : 64'd0);
      chk("o_valid", 64'(bus.o_valid), 64'(q.size() > 0));
      if (q.size() > 0) chk("o_data_bus", 64'(bus.o_data_bus), 64'(q[0]));
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      lg = 1;
    end else begin
      if (m_pop) void'(q.pop_front());
      if (m_push) begin
        q.push_back(m_din);
        lg = m_cmd;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_rdy;
    rst_n = 1'b0; kill = 1'b0; data_hi = '0; data_lo = '0;
    bus.i_src_valid = 2'b00; bus.i_ready = 1'b0;
    tick();
    check_en = 1;
    tick();
    rst_n = 1'b1;

    // Reset / idle
    @(negedge clk);
    chk("rst_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_en", 64'(bus.o_mux_en), 64'd0);
    chk("rst_ready", 64'(bus.o_src_ready), 64'd0);
    chk("rst_cmd", 64'(bus.o_mux_cmd), 64'd0);
    chk("rst_data", 64'(bus.o_data_bus), 64'd0);
    tick();

    // Single high source
    data_hi = 32'hFFFFFFFF; data_lo = 32'hAAAAAAAA;
    bus.i_src_valid = 2'b10; bus.i_ready = 1'b1;
    @(negedge clk);
    chk("single_cmd", 64'(bus.o_mux_cmd), 64'd1);
    chk("single_ready", 64'(bus.o_src_ready), 64'h2);
    tick();
    bus.i_src_valid = 2'b00;
    @(negedge clk);
    chk("single_valid", 64'(bus.o_valid), 64'd1);
    chk("single_data", 64'(bus.o_data_bus), 64'hFFFFFFFF);
    tick();
    tick();

    // Tie: the last winner was high, so low goes first.
    bus.i_src_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
`ifdef MUX_2X1_FIXED_PRIO_EN
      exp_rdy = 2'b01;
`else
      exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
      chk("tie_ready", 64'(bus.o_src_ready), 64'(exp_rdy));
      if (i > 0) begin
`ifdef MUX_2X1_FIXED_PRIO_EN
        chk("tie_data", 64'(bus.o_data_bus), 64'hAAAAAAAA);
`else
        chk("tie_data", 64'(bus.o_data_bus), (i % 2 == 1) ? 64'hAAAAAAAA : 64'hFFFFFFFF);
`endif
      end
      tick();
    end
    bus.i_src_valid = 2'b00;
    tick();
    tick();

    // Back-pressure: exactly DEPTH pushes, then the enable drops.
    bus.i_ready = 1'b0; bus.i_src_valid = 2'b01;
    for (int i = 0; i < 4; i++) begin
      data_lo = 32'h100 + 32'(i);
      @(negedge clk);
      chk("bp_en", 64'(bus.o_mux_en), (i < 2) ? 64'd1 : 64'd0);
      chk("bp_ready", 64'(bus.o_src_ready), (i < 2) ? 64'd1 : 64'd0);
      tick();
    end
    bus.i_ready = 1'b1; data_lo = 32'h200;
    @(negedge clk);
    chk("drain0_data", 64'(bus.o_data_bus), 64'h100);
    chk("drain0_en", 64'(bus.o_mux_en), 64'd0);
    tick();
    @(negedge clk);
    chk("drain1_data", 64'(bus.o_data_bus), 64'h101);
    chk("drain1_en", 64'(bus.o_mux_en), 64'd1);
    tick();

    // Invalid mux output: no push, and the last winner (low) is unchanged.
    kill = 1'b1;
    @(negedge clk);
    chk("inv_en", 64'(bus.o_mux_en), 64'd1);
    chk("inv_ready", 64'(bus.o_src_ready), 64'd0);
    tick();
    kill = 1'b0; bus.i_src_valid = 2'b11; data_hi = 32'h55;
    @(negedge clk);
`ifdef MUX_2X1_FIXED_PRIO_EN
    chk("inv_next_ready", 64'(bus.o_src_ready), 64'h1);
`else
    chk("inv_next_ready", 64'(bus.o_src_ready), 64'h2);
`endif
    tick();

    // Reset mid-operation with a full FIFO.
    bus.i_src_valid = 2'b00;
    tick(); tick(); tick();
    bus.i_ready = 1'b0; bus.i_src_valid = 2'b01;
    tick(); tick();
    @(negedge clk);
    chk("mid_full_en", 64'(bus.o_mux_en), 64'd0);
    bus.i_src_valid = 2'b00;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 64'(bus.o_valid), 64'd0);
    tick();
    bus.i_src_valid = 2'b11;
    @(negedge clk);
    chk("mid_rst_tie", 64'(bus.o_src_ready), 64'h1);
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      bus.i_src_valid = 2'($urandom_range(0, 3));
      bus.i_ready     = ($urandom_range(0, 3) != 0);
      kill            = ($urandom_range(0, 7) == 0);
      data_hi         = $urandom();
      data_lo         = $urandom();
      rst_n           = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_2x1_rr_out_stage.md
# mux_2x1_rr_out_stage

Sequential control and output stage that sits directly downstream of `mux_2x1_simple_comb`. It arbitrates round-robin between the mux's two valid-tagged inputs and drives the mux's `i_en`/`i_cmd`. It captures the selected `o_data_bus` into a small FIFO and presents it to the next NoC hop with valid/ready back-pressure. Together the pair forms a registered 2:1 merge node with per-source pop acknowledges.

## Interface
Parameters:
- `DATA_WIDTH`, 32, payload width; equals the mux `DATA_WIDTH`.
- `FIFO_DEPTH`, 2, output FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `i_src_valid`  in  2  source valids; the same vector wired to mux `i_valid`. Bit 1 = high branch, bit 0 = low branch.
- `o_src_ready`  out  2  one-hot pop acknowledge to the granted source.
- `o_mux_en`  out  1  drives mux `i_en`.
- `o_mux_cmd`  out  1  drives mux `i_cmd` (1 = high, 0 = low).
- `i_mux_valid`  in  1  mux `o_valid`.
- `i_mux_data`  in  DATA_WIDTH  mux `o_data_bus`.
- `o_valid`  out  1  FIFO head valid.
- `o_data_bus`  out  DATA_WIDTH  FIFO head data.
- `i_ready`  in  1  downstream accepts the head.

## Operation
- State:
  - `last_grant`: 1 bit.
  - FIFO storage, read/write pointers of log2(FIFO_DEPTH)+1 bits each, wrapping.
  - `full` and `empty` derived from the pointers.
- Arbitration (combinational, from registered state):
  - Requests = `i_src_valid` when `!full`; no requests when `full`.
  - One requester: grant that requester.
  - Both requesting: grant `~last_grant`.
  - No requests: `o_mux_cmd` holds `~last_grant`; `o_mux_en`=0.
- `o_mux_en` = any request, gated by `!full`.
- Push = `o_mux_en & i_mux_valid`. On push:
  - write `i_mux_data` at the write pointer;
  - assert `o_src_ready[grant]`=1 in the same cycle;
  - update `last_grant` to the granted index.
- `o_src_ready` is 0 whenever there is no push. If `o_mux_en`=1 and `i_mux_valid`=0 (invalid mux output), there is no push, no ready, and `last_grant` is unchanged.
- Pop = `o_valid & i_ready`; advances the read pointer.
- `o_valid` = `!empty`; `o_data_bus` = head entry.
- Simultaneous push and pop:
  - Allowed when not full; occupancy is unchanged.
  - When full, the push is blocked (full is registered, no same-cycle bypass). The pop still occurs, and the push resumes the next cycle.
- `o_data_bus` holds its value while `o_valid`=1 and `i_ready`=0.

## Timing
- Reset values:
  - `o_valid`=0, `o_src_ready`=0, `o_mux_en`=0.
  - `o_mux_cmd`=0; `last_grant` resets to 1, so low wins the first tie.
  - Pointers=0, FIFO empty.
  - `o_data_bus` = 0 (storage cleared).
- Reset asserted mid-operation discards all FIFO contents at that edge; outputs take reset values in the following cycle.
- Latency: a push on edge N gives `o_valid`=1 after edge N.
- Throughput: 1 push/cycle with concurrent pops. With `i_ready`=0 the stage accepts exactly FIFO_DEPTH pushes, then deasserts `o_mux_en`.
- `o_src_ready`, `o_mux_en` and `o_mux_cmd` are combinational from `i_src_valid`, `i_mux_valid` and registered state. There is no combinational path from `i_ready` to any output.

## Configuration
- `MUX_2X1_FIXED_PRIO_EN`:
  - Defined: fixed priority; when both sources request, low (bit 0) always wins; `last_grant` is not used.
  - Undefined (default): round-robin as specified above.

## Test plan
- Reset/idle: `rst_n`=0 for 2 cycles, then `i_src_valid`=2'b00 → `o_valid`=0, `o_mux_en`=0, `o_src_ready`=2'b00.
- Single source: `i_src_valid`=2'b10, mux data 32'hFFFFFFFF, `i_ready`=1 → `o_mux_cmd`=1, `o_src_ready`=2'b10; `o_valid`=1 with `o_data_bus`=32'hFFFFFFFF the next cycle.
- Round-robin tie: `i_src_valid`=2'b11 held 4 cycles, `i_ready`=1 → grants low, high, low, high; outputs 32'hAAAAAAAA and 32'hFFFFFFFF alternate. With `MUX_2X1_FIXED_PRIO_EN`, all four grants go to low.
- Back-pressure: `i_ready`=0 and `i_src_valid`=2'b01 for 4 cycles → exactly 2 pushes, then `o_mux_en`=0 and `o_src_ready`=0. Raising `i_ready` drains entries in order, and pushes resume the cycle after the first pop.
- Invalid mux output: `o_mux_en`=1 but `i_mux_valid`=0 → no push, `o_src_ready`=2'b00, `last_grant` unchanged.
- Reset mid-operation: FIFO holding 2 entries, `rst_n`=0 for one edge → `o_valid`=0 next cycle; the first tie after reset grants low.
